// File: rtl/pipe_word_serializer_pkg.sv
// Shared constants and FSM encoding for the pipeline word serializer.
package pipe_word_serializer_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_B0   = 2'b01,
    S_B1   = 2'b10,
    S_B2   = 2'b11
  } ser_state_e;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word buffer between the upstream pipeline and the serializer.
// Pushes are refused when full and pops when empty, so it cannot over/underflow.
module word_fifo2
  import pipe_word_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != 2'(DEPTH));
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; clr empties the buffer without touching data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_word_serializer.sv
// Accepts 24-bit words from a three-stage pipeline and emits them as three
// bytes, oldest byte first, over a valid/ready byte stream.
module pipe_word_serializer
  import pipe_word_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              Ld,
  input  logic              clr,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic [7:0]        word_cnt
);

  ser_state_e        state;
  ser_state_e        state_next;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_nonempty;
  logic              push;
  logic              pop;
  logic              hs;

  // Accept is decided from buffer occupancy only, never from a same-cycle pop.
  assign Ld            = word_valid && (fifo_count < 2'(DEPTH)) && !clr;
  assign push          = word_valid && Ld;
  assign hs            = dout_valid && dout_ready;
  assign fifo_nonempty = (fifo_count != 2'd0);

  word_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (word_in),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state and pop decision; clr overrides every other transition.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    if (clr) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            state_next = S_B0;
          end
        end
        S_B0: if (hs) state_next = S_B1;
        S_B1: if (hs) state_next = S_B2;
        S_B2: begin
          if (hs) begin
            if (fifo_nonempty) begin
              pop        = 1'b1;
              state_next = S_B0;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Byte outputs are a pure function of state and the held word.
  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    case (state)
      S_B0: begin
        dout       = shift_reg[7:0];
        dout_valid = 1'b1;
      end
      S_B1: begin
        dout       = shift_reg[15:8];
        dout_valid = 1'b1;
      end
      S_B2: begin
        dout       = shift_reg[23:16];
        dout_valid = 1'b1;
        dout_last  = 1'b1;
      end
      default: begin
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
      end
    endcase
  end

  // Capture the buffer head whenever a word leaves the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     shift_reg <= '0;
    else if (pop) shift_reg <= fifo_head;
  end

  // Count words whose last byte was accepted; flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                word_cnt <= 8'd0;
    else if (!clr && state == S_B2 && hs)    word_cnt <= word_cnt + 8'd1;
  end

endmodule

// File: tb/tb_pipe_word_serializer.sv
// Self-checking bench for pipe_word_serializer with a queue-based reference model.
module tb_pipe_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] word_in;
  logic        word_valid;
  logic        Ld;
  logic        clr;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic [7:0]  word_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered words, the word on the wire and its byte index.
  logic [23:0] mq[$];
  logic [23:0] mCur;
  int          mIdx;
  bit          mActive;
  logic [7:0]  mCnt;
  int          mWords;

  logic        obsLd;
  logic        obsValid;
  logic [7:0]  obsDout;
  logic        obsLast;
  logic [7:0]  obsCnt;
  int          ldCount;

  // Free-running clock.
  always #5 clk = ~clk;

  pipe_word_serializer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .Ld         (Ld),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .word_cnt   (word_cnt)
  );

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mCur    = '0;
    mIdx    = 0;
    mActive = 1'b0;
    mCnt    = 8'd0;
    mWords  = 0;
  endtask

  function automatic logic [7:0] modelDout();
    if (mActive) return mCur[8*mIdx +: 8];
    return 8'h00;
  endfunction

  // One clock edge of the reference: flush, else transmit a byte / fetch a word, then accept.
  task automatic modelEdge(input bit wv, input logic [23:0] w, input bit c, input bit rdy);
    bit accept;
    bit takeNext;
    accept   = wv && (mq.size() < 2) && !c;
    takeNext = 1'b0;
    if (c) begin
      mq.delete();
      mActive = 1'b0;
    end else begin
      if (!mActive) begin
        takeNext = (mq.size() > 0);
      end else if (rdy) begin
        if (mIdx == 2) begin
          mCnt++;
          mWords++;
          if (mq.size() > 0) takeNext = 1'b1;
          else               mActive  = 1'b0;
        end else begin
          mIdx++;
        end
      end
      if (takeNext) begin
        mCur    = mq.pop_front();
        mIdx    = 0;
        mActive = 1'b1;
      end
      if (accept) mq.push_back(w);
    end
  endtask

  // Drive one cycle from a falling edge, check outputs 1ns later, advance the model at the rising edge.
  task automatic applyStimulus(input bit wv, input logic [23:0] w, input bit c, input bit rdy);
    bit ldExp;
    word_valid = wv;
    word_in    = w;
    clr        = c;
    dout_ready = rdy;
    #1;
    ldExp    = wv && (mq.size() < 2) && !c;
    obsLd    = Ld;
    obsValid = dout_valid;
    obsDout  = dout;
    obsLast  = dout_last;
    obsCnt   = word_cnt;
    if (Ld) ldCount++;
    checkOutput("ld",    32'(Ld),         32'(ldExp));
    checkOutput("valid", 32'(dout_valid), 32'(mActive));
    checkOutput("dout",  32'(dout),       32'(modelDout()));
    checkOutput("last",  32'(dout_last),  32'(mActive && mIdx == 2));
    checkOutput("cnt",   32'(word_cnt),   32'(mCnt));
    @(posedge clk);
    modelEdge(wv, w, c, rdy);
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst        = 1'b0;
    word_valid = 1'b0;
    clr        = 1'b0;
    dout_ready = 1'b0;
    word_in    = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [7:0] seq [3];
    logic       seqLast [3];
    int         guard;
    bit         wv, c, rdy;

    rst        = 1'b0;
    word_valid = 1'b0;
    clr        = 1'b0;
    dout_ready = 1'b0;
    word_in    = '0;
    ldCount    = 0;
    modelReset();
    #3;
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_dout",  32'(dout),       32'd0);
    checkOutput("rst_last",  32'(dout_last),  32'd0);
    checkOutput("rst_cnt",   32'(word_cnt),   32'd0);
    checkOutput("rst_ld0",   32'(Ld),         32'd0);
    word_valid = 1'b1;
    #1;
    checkOutput("rst_ld1",   32'(Ld),         32'd1);
    word_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();

    // Single word with an always-ready sink.
    applyStimulus(1'b1, 24'hC3B2A1, 1'b0, 1'b1);
    checkOutput("single_ld", 32'(obsLd), 32'd1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("latency_gap", 32'(obsValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      seq[i]     = obsDout;
      seqLast[i] = obsLast;
      checkOutput("single_valid", 32'(obsValid), 32'd1);
    end
    checkOutput("byte0", 32'(seq[0]), 32'hA1);
    checkOutput("byte1", 32'(seq[1]), 32'hB2);
    checkOutput("byte2", 32'(seq[2]), 32'hC3);
    checkOutput("last0", 32'(seqLast[0]), 32'd0);
    checkOutput("last1", 32'(seqLast[1]), 32'd0);
    checkOutput("last2", 32'(seqLast[2]), 32'd1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("single_cnt", 32'(obsCnt), 32'd1);

    // Backpressure while the middle byte is on the wire.
    resetDut();
    applyStimulus(1'b1, 24'h665544, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("bp_dout",  32'(obsDout),  32'h55);
      checkOutput("bp_valid", 32'(obsValid), 32'd1);
      checkOutput("bp_cnt",   32'(obsCnt),   32'd0);
    end
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("bp_cnt_done", 32'(obsCnt), 32'd1);

    // Full buffer: upstream keeps offering, sink stalled.
    resetDut();
    ldCount = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 24'(32'h100000 + i * 32'h010101), 1'b0, 1'b0);
    checkOutput("full_accepts", 32'(ldCount), 32'd3);
    checkOutput("full_ld_low",  32'(obsLd),   32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("full_cnt", 32'(obsCnt), 32'd3);

    // Back-to-back words stream without a bubble.
    resetDut();
    applyStimulus(1'b1, 24'h030201, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h060504, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("b2b_valid", 32'(obsValid), 32'd1);
      checkOutput("b2b_byte",  32'(obsDout),  32'(i + 1));
    end
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("b2b_cnt", 32'(obsCnt), 32'd2);

    // Asynchronous reset in the middle of a word.
    applyStimulus(1'b1, 24'hABCDEF, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    word_valid = 1'b1;
    clr        = 1'b0;
    dout_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(dout_valid), 32'd0);
    checkOutput("arst_dout",  32'(dout),       32'd0);
    checkOutput("arst_last",  32'(dout_last),  32'd0);
    checkOutput("arst_cnt",   32'(word_cnt),   32'd0);
    checkOutput("arst_ld",    32'(Ld),         32'd1);
    word_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();

    // Flush in the middle byte with another word buffered.
    applyStimulus(1'b1, 24'h111111, 1'b0, 1'b1);
    applyStimulus(1'b1, 24'h222222, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 24'h333333, 1'b1, 1'b1);
    checkOutput("clr_ld", 32'(obsLd), 32'd0);
    applyStimulus(1'b1, 24'h444444, 1'b0, 1'b0);
    checkOutput("clr_valid", 32'(obsValid), 32'd0);
    checkOutput("clr_ld_re", 32'(obsLd),    32'd1);
    checkOutput("clr_cnt",   32'(obsCnt),   32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);

    // Word counter wrap after 256 words.
    resetDut();
    guard = 0;
    while (mWords < 256 && guard < 3000) begin
      applyStimulus(1'b1, 24'($urandom), 1'b0, 1'b1);
      guard++;
    end
    checkOutput("wrap_reached", 32'(mWords >= 256), 32'd1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
    checkOutput("wrap_cnt", 32'(obsCnt), 32'd0);

    // Randomized traffic with occasional flushes.
    resetDut();
    for (int i = 0; i < 1500; i++) begin
      wv  = ($urandom_range(0, 9) < 7);
      c   = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      applyStimulus(wv, 24'($urandom), c, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_word_serializer.md
PIPE_WORD_SERIALIZER -- requirements
Module: pipe_word_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk and rst.
REQ-002 Parameter DEPTH, default 2: word buffer entries, fixed at 2 in this revision.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port word_in  input  24  packed word {P2,P1,P0} from the three-stage pipeline; P0 (bits 7:0) is the oldest byte.
REQ-006 Port word_valid  input  1  upstream pipeline holds a complete word (full/wait state).
REQ-007 Port Ld  output  1  load/accept strobe returned to the upstream pipeline controller.
REQ-008 Port clr  input  1  synchronous flush.
REQ-009 Port dout  output  8  serialized byte.
REQ-010 Port dout_valid  output  1  dout holds a valid byte.
REQ-011 Port dout_ready  input  1  downstream accepts dout this cycle.
REQ-012 Port dout_last  output  1  high with the third byte of each word.
REQ-013 Port word_cnt  output  8  count of fully transmitted words, wraps 255->0.

Function
REQ-014 Ld SHALL be combinational: Ld = word_valid AND (buffer count < 2) AND NOT clr.
REQ-015 On a rising edge with word_valid=1 and Ld=1, word_in SHALL be pushed into the 2-entry FIFO; a push never depends on a same-cycle pop (no pass-through when full).
REQ-016 Serializer FSM states: S_IDLE, S_B0, S_B1, S_B2; a byte handshake is dout_valid AND dout_ready.
REQ-017 S_IDLE: dout_valid=0; if FIFO non-empty, pop head into 24-bit shift register and go to S_B0 next cycle.
REQ-018 S_B0/S_B1/S_B2: dout_valid=1, dout = bits 7:0 / 15:8 / 23:16 of the shift register; dout_last=1 only in S_B2.
REQ-019 S_B0->S_B1 and S_B1->S_B2 SHALL occur only on handshake; without handshake, state and dout hold stable.
REQ-020 S_B2 on handshake: word_cnt increments by 1 (mod 256); if FIFO non-empty, pop the next word and go to S_B0 (no bubble), else go to S_IDLE.
REQ-021 Latency: a word pushed into an empty FIFO while in S_IDLE SHALL present its first byte with dout_valid=1 two cycles after the push edge.
REQ-022 Simultaneous push and pop SHALL leave the FIFO count unchanged and preserve word order.
REQ-023 clr=1 SHALL, at the next edge, empty the FIFO, enter S_IDLE, and drop dout_valid and dout_last; word_cnt is not cleared; clr has priority over push, pop and handshake.
REQ-024 The FIFO SHALL never overflow or underflow; a pop occurs only when count>0.

Reset
REQ-025 While rst=0, regardless of clk: FSM=S_IDLE, FIFO count=0, pointers=0, shift register=0, dout=0, dout_valid=0, dout_last=0, word_cnt=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word without incrementing word_cnt; Ld SHALL follow REQ-014 with count=0 immediately after reset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (S_IDLE=2'b00, S_B0=2'b01, S_B1=2'b10, S_B2=2'b11) and the byte width 8 / word width 24 constants.
REQ-028 The 2-entry word FIFO SHALL be a sub-module named word_fifo2 (push, pop, count, head); FSM and shift register stay in the top.

Verification
REQ-029 Single word: reset, word_in=24'hC3B2A1, word_valid one cycle, dout_ready=1 -> Ld=1 that cycle, bytes A1, B2, C3 on consecutive cycles, dout_last only on C3, word_cnt=1.
REQ-030 Backpressure: dout_ready=0 for 5 cycles during S_B1 -> dout holds B2 with dout_valid=1, no state change, word_cnt unchanged.
REQ-031 Full buffer: word_valid held high with dout_ready=0 -> exactly 2 pushes (3 counting the word in the shift register), then Ld=0 until a pop; no word is lost or duplicated.
REQ-032 Back-to-back: words 24'h030201 and 24'h060504 buffered -> bytes 01..06 with no idle cycle between 03 and 04, word_cnt=2.
REQ-033 Flush and reset: clr=1 in S_B1 with one word buffered -> next cycle dout_valid=0, Ld re-asserts, word_cnt unchanged; rst=0 mid-word -> all outputs 0 asynchronously.
REQ-034 Wrap: 256 words transmitted -> word_cnt returns to 8'h00.
